decoder_2to4_pipe: RTL and testbench



---
 rtl/decoder_pkg.sv | 23 ++
 rtl/skid_buffer.sv | 72 +++++++
 rtl/decoder_2to4_pipe.sv | 70 +++++++
 tb/tb_decoder_2to4_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and the code-to-one-hot helper for the 2-to-4 pipelined decoder.
package decoder_pkg;

  localparam int unsigned DEF_SEL_W = 2;
  localparam int unsigned DEF_OUT_W = 2 ** DEF_SEL_W;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned CNT_MAX   = (2 ** DEF_CNT_W) - 1;

  // Output width for a given select-code width.
  function automatic int unsigned out_w(input int unsigned sel_w);
    return 2 ** sel_w;
  endfunction

  // Bit `code` set when enabled, all-zero when disabled.
  function automatic logic [DEF_OUT_W-1:0] onehot_of(input logic [DEF_SEL_W-1:0] code,
                                                    input logic                 en);
    logic [DEF_OUT_W-1:0] word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with registered ready; main register drives the output.
module skid_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              ready_q, ready_d;
  logic              acc;
  logic              dlv;

  assign acc = in_valid & ready_q;
  assign dlv = m_valid_q & out_ready;

  // Next-state: refill main from skid first, then from input; overflow lands in skid.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (!m_valid_q || dlv) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
        s_data_d  = '0;
      end else if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
    ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

endmodule

// File: rtl/decoder_2to4_pipe.sv
// Registered binary-to-one-hot decoder behind a skid buffer, with a saturating delivery counter.
module decoder_2to4_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_code,
  input  logic                  in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**SEL_W)-1:0] out_onehot,
  output logic [SEL_W-1:0]      out_code,
  output logic                  out_en,
  output logic [CNT_W-1:0]      dec_count
);

  localparam int unsigned OUT_W  = out_w(SEL_W);
  localparam int unsigned DATA_W = OUT_W + SEL_W + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [OUT_W-1:0]  dec_onehot;
  logic [DATA_W-1:0] buf_in;
  logic [DATA_W-1:0] buf_out;

  // Decode at the input so only registered words ever reach the outputs.
  generate
    if (SEL_W == DEF_SEL_W) begin : g_pkg_dec
      assign dec_onehot = onehot_of(in_code, in_en);
    end else begin : g_gen_dec
      always_comb begin
        dec_onehot = '0;
        if (in_en) dec_onehot[in_code] = 1'b1;
      end
    end
  endgenerate

  assign buf_in = {dec_onehot, in_code, in_en};

  skid_buffer #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_onehot = buf_out[DATA_W-1 -: OUT_W];
  assign out_code   = buf_out[SEL_W:1];
  assign out_en     = buf_out[0];

  // Delivered-transfer counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= '0;
    end else if (out_valid && out_ready && (dec_count != CNT_SAT)) begin
      dec_count <= dec_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_2to4_pipe.sv
// Self-checking bench for decoder_2to4_pipe against a queue-based transfer model.
module tb_decoder_2to4_pipe;

  localparam int CNT_W_TB = 3;
  localparam int CNT_MAX_M = (2 ** CNT_W_TB) - 1;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] code;
    logic       en;
  } item_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_code;
  logic                in_en;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_onehot;
  logic [1:0]          out_code;
  logic                out_en;
  logic [CNT_W_TB-1:0] dec_count;

  int    checks;
  int    errors;
  item_t exp_q[$];
  int    cnt_m;
  logic  ready_m;

  decoder_2to4_pipe #(
    .SEL_W (2),
    .CNT_W (CNT_W_TB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code),
    .out_en     (out_en),
    .dec_count  (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs, clock it, and advance the transfer model.
  task automatic step(input logic v, input logic [1:0] c, input logic e, input logic r);
    item_t it;
    logic  acc;
    logic  dlv;
    in_valid  = v;
    in_code   = c;
    in_en     = e;
    out_ready = r;
    acc = v && ready_m;
    dlv = r && (exp_q.size() != 0);
    @(posedge clk);
    if (dlv) begin
      void'(exp_q.pop_front());
      if (cnt_m < CNT_MAX_M) cnt_m++;
    end
    if (acc) begin
      it.oh   = e ? 4'(2 ** int'(c)) : 4'd0;
      it.code = c;
      it.en   = e;
      exp_q.push_back(it);
    end
    ready_m = (exp_q.size() < 2);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    cnt_m   = 0;
    ready_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_code = 2'd0; in_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete(); cnt_m = 0; ready_m = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot got %b want 0000", out_onehot); end
    checks++; if (out_code !== 2'd0 || out_en !== 1'b0) begin errors++; $display("FAIL reset_echo got code=%0d en=%b want 0/0", out_code, out_en); end
    checks++; if (dec_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dec_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 2'b10, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_onehot !== 4'b0100 || out_code !== 2'd2) begin
      errors++; $display("FAIL single_out got v=%b oh=%b code=%0d want 1/0100/2", out_valid, out_onehot, out_code); end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    checks++; if (dec_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", dec_count); end
    checks++; if (out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
      errors++; $display("FAIL single_drain got v=%b oh=%b want 0/0000", out_valid, out_onehot); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want [4];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000;
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 1'b1, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_onehot !== want[i]) begin
        errors++; $display("FAIL b2b_onehot[%0d] got v=%b oh=%b want 1/%b", i, out_valid, out_onehot, want[i]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    checks++; if (dec_count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", dec_count); end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0);
    checks++; if (out_onehot !== 4'b1000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_first got oh=%b rdy=%b want 1000/1", out_onehot, in_ready); end
    step(1'b1, 2'd1, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_onehot !== 4'b1000) begin
      errors++; $display("FAIL stall_full got rdy=%b oh=%b want 0/1000", in_ready, out_onehot); end
    step(1'b1, 2'd2, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_onehot !== 4'b1000 || out_code !== 2'd3) begin
      errors++; $display("FAIL stall_hold got rdy=%b oh=%b code=%0d want 0/1000/3", in_ready, out_onehot, out_code); end
    step(1'b1, 2'd2, 1'b1, 1'b1);
    checks++; if (out_onehot !== 4'b0010 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_second got oh=%b rdy=%b want 0010/1", out_onehot, in_ready); end
    step(1'b1, 2'd2, 1'b1, 1'b1);
    checks++; if (out_onehot !== 4'b0100 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_third got v=%b oh=%b want 1/0100", out_valid, out_onehot); end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    checks++; if (dec_count !== 3'd3 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_count got cnt=%0d v=%b want 3/0", dec_count, out_valid); end
  endtask

  task automatic test_disabled();
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 2'b11, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_onehot !== 4'b0000 || out_en !== 1'b0 || out_code !== 2'd3) begin
      errors++; $display("FAIL disabled_out got v=%b oh=%b en=%b code=%0d want 1/0000/0/3", out_valid, out_onehot, out_en, out_code); end
    step(1'b0, 2'd0, 1'b0, 1'b1);
    checks++; if (dec_count !== 3'd1) begin errors++; $display("FAIL disabled_count got %0d want 1", dec_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      step((k <= 10), 2'(k % 4), 1'b1, 1'b1);
      checks++; if (int'(dec_count) != ((k - 1 < 7) ? k - 1 : 7)) begin
        errors++; $display("FAIL sat_count[%0d] got %0d want %0d", k, dec_count, (k - 1 < 7) ? k - 1 : 7); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 2'd0, 1'b1, 1'b1);
    step(1'b1, 2'd1, 1'b1, 1'b1);
    step(1'b1, 2'd3, 1'b1, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b0 || dec_count !== 3'd1 || out_onehot !== 4'b0010) begin
      errors++; $display("FAIL midrst_setup got rdy=%b cnt=%0d oh=%b want 0/1/0010", in_ready, dec_count, out_onehot); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || dec_count !== 3'd0) begin
      errors++; $display("FAIL midrst_async got v=%b oh=%b cnt=%0d want 0/0000/0", out_valid, out_onehot, dec_count); end
    exp_q.delete(); cnt_m = 0; ready_m = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0 || dec_count !== 3'd0) begin
        errors++; $display("FAIL midrst_idle[%0d] got v=%b cnt=%0d want 0/0", i, out_valid, dec_count); end
    end
    step(1'b1, 2'd1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_onehot !== 4'b0010) begin
      errors++; $display("FAIL midrst_new got v=%b oh=%b want 1/0010", out_valid, out_onehot); end
  endtask

  task automatic test_random();
    item_t      head;
    logic       ev;
    logic [3:0] eoh;
    logic [1:0] ecode;
    logic       een;
    do_reset();
    step(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) != 0));
      ev = (exp_q.size() != 0);
      if (ev) begin
        head = exp_q[0];
        eoh = head.oh; ecode = head.code; een = head.en;
      end else begin
        eoh = 4'd0; ecode = 2'd0; een = 1'b0;
      end
      checks++; if (out_valid !== ev || out_onehot !== eoh || out_code !== ecode || out_en !== een) begin
        errors++; $display("FAIL rand_out[%0d] got v=%b oh=%b code=%0d en=%b want %b/%b/%0d/%b",
                           i, out_valid, out_onehot, out_code, out_en, ev, eoh, ecode, een); end
      checks++; if (in_ready !== ready_m || int'(dec_count) != cnt_m) begin
        errors++; $display("FAIL rand_ctl[%0d] got rdy=%b cnt=%0d want %b/%0d", i, in_ready, dec_count, ready_m, cnt_m); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_disabled();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
